// File: rtl/glbl_rst_seq_if.sv
// Bus between the global reset register and the reset sequencer.
// The master drives the release requests; the slave returns the sequenced resets and status.
interface glbl_rst_seq_if #(
  parameter int NDOM = 8
);
  logic [NDOM-1:0] rst_req_n;
  logic [NDOM-1:0] dom_rst_n;
  logic            busy;
  logic [3:0]      cur_dom;
  logic            rel_pulse;

  modport master (
    output rst_req_n,
    input  dom_rst_n,
    input  busy,
    input  cur_dom,
    input  rel_pulse
  );

  modport slave (
    input  rst_req_n,
    output dom_rst_n,
    output busy,
    output cur_dom,
    output rel_pulse
  );
endinterface

// File: rtl/glbl_rst_seq.sv
// Global reset sequencer: asserts domain resets immediately and releases them one at a time,
// lowest index first, REL_DLY cycles after selection. Define GLBL_RST_SEQ_STRETCH_EN for minimum assertion width.
module glbl_rst_seq #(
  parameter int NDOM       = 8,
  parameter int REL_DLY    = 16,
  parameter int MIN_ASSERT = 4
) (
  input logic           clk,
  input logic           s_reset,
  glbl_rst_seq_if.slave bus
);
  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [3:0]      cur_dom_q, cur_dom_d;
  logic            busy_q, busy_d;
  logic            rel_pulse_q, rel_pulse_d;
  logic [NDOM-1:0] dom_rst_n_q, dom_rst_n_d;
  logic [NDOM-1:0] str_clear;
  logic [NDOM-1:0] pending;
  logic [NDOM-1:0] cur_mask;
  logic            sel_found;
  logic [3:0]      sel_idx;

  if (NDOM < 1 || NDOM > 16 || REL_DLY < 1 || REL_DLY > 255 ||
      MIN_ASSERT < 1 || MIN_ASSERT > 255) begin : g_param_check
    $error("glbl_rst_seq: parameter out of range");
  end

`ifdef GLBL_RST_SEQ_STRETCH_EN
  // Each falling edge of a domain reset arms its counter; the domain cannot be selected until it drains.
  for (genvar gi = 0; gi < NDOM; gi++) begin : g_stretch
    logic [7:0] str_q, str_d;

    always_comb begin
      str_d = str_q;
      if (dom_rst_n_q[gi] && !dom_rst_n_d[gi]) begin
        str_d = 8'(MIN_ASSERT);
      end else if (str_q != 8'd0) begin
        str_d = str_q - 8'd1;
      end
    end

    always_ff @(posedge clk) begin
      if (s_reset) begin
        str_q <= 8'd0;
      end else begin
        str_q <= str_d;
      end
    end

    assign str_clear[gi] = (str_q == 8'd0);
  end
`else
  assign str_clear = '1;
`endif

  always_comb begin
    pending   = bus.rst_req_n & ~dom_rst_n_q & str_clear;
    sel_found = 1'b0;
    sel_idx   = 4'd0;
    // Scan downwards so the lowest pending index wins.
    for (int i = NDOM - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_found = 1'b1;
        sel_idx   = 4'(i);
      end
    end
    cur_mask = '0;
    for (int i = 0; i < NDOM; i++) begin
      cur_mask[i] = (cur_dom_q == 4'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_dom_d   = cur_dom_q;
    busy_d      = busy_q;
    rel_pulse_d = 1'b0;
    // A low request always wins on its own bit, whatever the FSM is doing.
    dom_rst_n_d = dom_rst_n_q & bus.rst_req_n;

    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          state_d   = ST_WAIT;
          cnt_d     = 8'(REL_DLY);
          cur_dom_d = sel_idx;
          busy_d    = 1'b1;
        end
      end
      ST_WAIT: begin
        if ((bus.rst_req_n & cur_mask) == '0) begin
          state_d   = ST_IDLE;
          cnt_d     = 8'd0;
          cur_dom_d = 4'd0;
          busy_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            dom_rst_n_d = dom_rst_n_d | cur_mask;
            rel_pulse_d = 1'b1;
            state_d     = ST_IDLE;
            cur_dom_d   = 4'd0;
            busy_d      = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (s_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      cur_dom_q   <= 4'd0;
      busy_q      <= 1'b0;
      rel_pulse_q <= 1'b0;
      dom_rst_n_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_dom_q   <= cur_dom_d;
      busy_q      <= busy_d;
      rel_pulse_q <= rel_pulse_d;
      dom_rst_n_q <= dom_rst_n_d;
    end
  end

  assign bus.dom_rst_n = dom_rst_n_q;
  assign bus.busy      = busy_q;
  assign bus.cur_dom   = cur_dom_q;
  assign bus.rel_pulse = rel_pulse_q;
endmodule
